// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART transmit scheduler.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      SEND  = 2'd2,
      GAP   = 2'd3
   } state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // One shared counter must reach both the start timeout and the gap length.
   function automatic int cnt_width(input int timeout, input int gap);
      return $clog2(max_int(timeout, gap) + 1);
   endfunction

   // A single requester still needs a one-bit index.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DFLT_NUM_REQ = 4;
   localparam int GRANT_W      = id_width(DFLT_NUM_REQ);

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Client request bus plus transmitter handshake of the scheduler.
interface uart_tx_scheduler_if
   import uart_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_BITS = 8
);
   localparam int ID_W = id_width(NUM_REQ);

   logic [NUM_REQ-1:0]           req;
   logic [NUM_REQ*DATA_BITS-1:0] req_data;
   logic [NUM_REQ-1:0]           ack;
   logic                         transmit;
   logic [DATA_BITS-1:0]         TxData;
   logic                         busy;
   logic [ID_W-1:0]              grant_id;
   logic                         active;
   logic                         start_err;

   modport master (
      input  req, req_data, busy,
      output ack, transmit, TxData, grant_id, active, start_err
   );

   modport slave (
      output req, req_data, busy,
      input  ack, transmit, TxData, grant_id, active, start_err
   );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above rr_ptr, wrapping.
module uart_rr_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] win_onehot,
   output logic [ID_W-1:0]    win_idx
);

   logic [ID_W:0] cand;
   logic          found;

   // Walk the requesters starting at rr_ptr; one extra bit keeps the wrap exact.
   always_comb begin
      win_onehot = '0;
      win_idx    = '0;
      found      = 1'b0;
      cand       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
         if (cand >= (ID_W+1)'(NUM_REQ)) begin
            cand = cand - (ID_W+1)'(NUM_REQ);
         end
         if (!found && req[cand[ID_W-1:0]]) begin
            found   = 1'b1;
            win_idx = cand[ID_W-1:0];
         end
      end
      if (found) begin
         win_onehot = NUM_REQ'(1) << win_idx;
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter between NUM_REQ clients.
//
// state | meaning
// IDLE  | waiting for a request while the transmitter is not busy
// START | transmit held high until busy rises or the start timeout expires
// SEND  | frame in progress, waiting for busy to fall
// GAP   | inter-frame idle time before re-arbitration
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int DATA_BITS     = 8,
   parameter int NUM_REQ       = 4,
   parameter int START_TIMEOUT = 65535,
   parameter int GAP_CYCLES    = 16
) (
   input  logic               clk,
   input  logic               reset,
   uart_tx_scheduler_if.master bus
);

   localparam int ID_W  = id_width(NUM_REQ);
   localparam int CNT_W = cnt_width(START_TIMEOUT, GAP_CYCLES);
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [ID_W-1:0]  PTR_MAX    = ID_W'(NUM_REQ - 1);
   // With no gap configured, a finished or aborted frame returns straight to IDLE.
   localparam state_e AFTER_FRAME = (GAP_CYCLES == 0) ? IDLE : GAP;

   state_e               state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [ID_W-1:0]      rr_ptr, rr_ptr_nxt;
   logic [ID_W-1:0]      grant_id_q, grant_id_nxt;
   logic [ID_W-1:0]      win_idx;
   logic [NUM_REQ-1:0]   ack_q, ack_nxt, win_onehot;
   logic [DATA_BITS-1:0] tx_data_q, tx_data_nxt;
   logic                 transmit_q, transmit_nxt;
   logic                 start_err_q, start_err_nxt;
   logic [DATA_BITS-1:0] req_word [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
      assign req_word[g] = bus.req_data[g*DATA_BITS +: DATA_BITS];
   end

   uart_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_arb (
      .req        (bus.req),
      .rr_ptr     (rr_ptr),
      .win_onehot (win_onehot),
      .win_idx    (win_idx)
   );

   // Next-state and registered-output decisions; busy beats a same-cycle timeout.
   always_comb begin
      state_nxt     = state;
      rr_ptr_nxt    = rr_ptr;
      grant_id_nxt  = grant_id_q;
      tx_data_nxt   = tx_data_q;
      transmit_nxt  = transmit_q;
      ack_nxt       = '0;
      start_err_nxt = 1'b0;
      cnt_nxt       = cnt;
      unique case (state)
         IDLE: begin
            if (|bus.req && !bus.busy) begin
               state_nxt    = START;
               tx_data_nxt  = req_word[win_idx];
               grant_id_nxt = win_idx;
               ack_nxt      = win_onehot;
               transmit_nxt = 1'b1;
               rr_ptr_nxt   = (win_idx == PTR_MAX) ? '0 : win_idx + 1'b1;
            end
         end
         START: begin
            if (bus.busy) begin
               transmit_nxt = 1'b0;
               state_nxt    = SEND;
            end else if (cnt == START_LAST) begin
               transmit_nxt  = 1'b0;
               start_err_nxt = 1'b1;
               state_nxt     = AFTER_FRAME;
            end
         end
         SEND: begin
            if (!bus.busy) begin
               state_nxt = AFTER_FRAME;
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (state_nxt != state) begin
         cnt_nxt = '0;
      end else if (state == START || state == GAP) begin
         cnt_nxt = cnt + 1'b1;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         rr_ptr      <= '0;
         grant_id_q  <= '0;
         tx_data_q   <= '0;
         transmit_q  <= 1'b0;
         ack_q       <= '0;
         start_err_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         rr_ptr      <= rr_ptr_nxt;
         grant_id_q  <= grant_id_nxt;
         tx_data_q   <= tx_data_nxt;
         transmit_q  <= transmit_nxt;
         ack_q       <= ack_nxt;
         start_err_q <= start_err_nxt;
      end
   end

   assign bus.ack       = ack_q;
   assign bus.transmit  = transmit_q;
   assign bus.TxData    = tx_data_q;
   assign bus.grant_id  = grant_id_q;
   assign bus.start_err = start_err_q;
   assign bus.active    = (state == START) || (state == SEND);

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART transmitter (transmit/TxData/busy interface) between NUM_REQ requesters using round-robin arbitration.
- Latches one word per grant and holds transmit until the transmitter's busy rises. Then waits for busy to fall, inserts an inter-frame gap, and re-arbitrates.
- Sits between client logic and the UART top level. Runs on the system clock; busy is already synchronous to clk.
- Provides a start-timeout watchdog so that a transmitter that never goes busy cannot stall the scheduler.

Parameters:
- DATA_BITS, 8, width of one UART data word.
- NUM_REQ, 4, number of requesters; must be 2 or more.
- START_TIMEOUT, 65535, clk cycles allowed in START for busy to rise before the frame is aborted; must be 1 or more.
- GAP_CYCLES, 16, idle clk cycles inserted after each frame or abort; 0 means no gap.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high reset.
- req, input, NUM_REQ, per-requester request; held high until ack.
- req_data, input, NUM_REQ*DATA_BITS, requester i data in bits [i*DATA_BITS +: DATA_BITS]; stable while req[i] is high.
- ack, output, NUM_REQ, one-cycle pulse: the word from requester i has been latched.
- transmit, output, 1, start request to the transmitter.
- TxData, output, DATA_BITS, word to the transmitter; stable from START until busy falls.
- busy, input, 1, transmitter busy flag.
- grant_id, output, $clog2(NUM_REQ), index of the requester that owns the current frame.
- active, output, 1, high in START and SEND.
- start_err, output, 1, one-cycle pulse when a start timeout occurs.

Behaviour:
- Reset values: state=IDLE, transmit=0, TxData=0, ack=0, grant_id=0, active=0, start_err=0, rr_ptr=0, cnt=0.
- Reset mid-frame returns to IDLE immediately. transmit drops on the next cycle; the transmitter's own frame is not tracked.
- Counter: one shared counter, width $clog2(max(START_TIMEOUT,GAP_CYCLES)+1). It clears on every state entry.
- IDLE:
  - If |req and busy==0 at edge k, the winner is the first set req bit searching from rr_ptr upward, wrapping at NUM_REQ.
  - At edge k: TxData <= req_data[winner], grant_id <= winner, ack[winner] <= 1, transmit <= 1, rr_ptr <= winner+1 (mod NUM_REQ). Go to START.
  - ack is high and transmit rises during cycle k+1 (latency 1).
  - If busy==1 in IDLE, no grant is made; wait.
- START:
  - transmit is held high.
  - busy==1: transmit <= 0, go to SEND.
  - Else, when cnt reaches START_TIMEOUT-1: transmit <= 0, start_err pulse, go to GAP.
  - If busy==1 and the timeout occur in the same cycle, busy wins: no error.
- SEND: wait for busy==0, then go to GAP.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE.
  - If GAP_CYCLES==0, go from SEND or START-abort directly to IDLE.
- ack:
  - Only ever one-hot or zero; never more than one pulse per grant.
  - The requester must deassert req[i] or present new data in the cycle after ack.
  - If req[i] stays high, it is a new request and is eligible at the next arbitration.
- A req deasserted before being granted is simply not served; it has no side effects.
- Fairness: with all req high, the grant order is 0,1,2,...,NUM_REQ-1,0,...
- A single persistent requester is served back-to-back, limited only by frame and gap time.
- A req rising in any state other than IDLE waits; no request is lost while it is held.
- req_data of non-winning requesters is ignored.

Decomposition:
- Package uart_pkg holds:
  - the state enum {IDLE, START, SEND, GAP};
  - a clog2/max helper for counter width;
  - a localparam for the grant_id width.
- One sub-module, uart_rr_arbiter: combinational. Inputs req and rr_ptr; outputs the one-hot winner and its encoded index. Parameterised by NUM_REQ.

Test Plan:
- Reset, then a single request: req=4'b0100 with data 8'hA5, busy model rises 3 clk after transmit and stays high 100 clk.
  - Required: ack=4'b0100 one cycle after req, TxData=8'hA5, grant_id=2.
  - Required: transmit high exactly 3 cycles, active high until busy falls, then a 16-cycle gap.
- All four requesters with data 8'h10..8'h13 and req held high.
  - Required: grants in order 0,1,2,3,0 and TxData sequence 10,11,12,13,10.
- Start timeout with START_TIMEOUT=8: busy stuck at 0.
  - Required: transmit high 8 cycles, start_err one pulse, GAP entered, then re-arbitration with rr_ptr advanced.
- busy rises in the same cycle as the timeout expires.
  - Required: no start_err, state SEND.
- Reset asserted during SEND.
  - Required: outputs at reset values next cycle, rr_ptr=0. A subsequent req=4'b1001 grants requester 0 first.
- GAP_CYCLES=0 with busy already high at req.
  - Required: no ack until busy falls. Back-to-back frames are separated only by the IDLE cycle.
